// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] an_off(
    input int n,
    input bit active_low
  );
    return active_low ? ((32'd1 << n) - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/BCD7.sv
// Hex nibble to seven-segment pattern {g..a}, active-high.
module BCD7 (
  input  logic [3:0] din,
  output logic [6:0] seg
);

  always_comb begin
    unique case (din)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display
// with frame-synchronous double buffering and leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int CLK_DIV       = 50000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = idx_w(NUM_DIGITS);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    NUM_DIGITS'(an_off(NUM_DIGITS, AN_ACTIVE_LOW));

  logic [PW-1:0]         ps_q, ps_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d;
  logic                  pvld_q, pvld_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [NUM_DIGITS-1:0] ddp_q, ddp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic                  tick, wrap;
  logic [3:0]            nib;
  logic [6:0]            nib_seg;
  logic                  nib_dp, blank_cur, run;
  logic [NUM_DIGITS-1:0] zero_up;

  BCD7 u_bcd7 (
    .din (nib),
    .seg (nib_seg)
  );

  // zero_up[i]: nibbles i..top are all zero
  always_comb begin
    nib       = 4'h0;
    nib_dp    = 1'b0;
    blank_cur = 1'b0;
    zero_up   = '0;
    run       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run        = run & (disp_q[4*i +: 4] == 4'h0);
      zero_up[i] = run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = disp_q[4*i +: 4];
        nib_dp    = ddp_q[i];
        blank_cur = blank_lz && (i != 0) && zero_up[i];
      end
    end
  end

  always_comb begin
    tick  = en && (ps_q == PS_LAST);
    wrap  = tick && (idx_q == IDX_LAST);
    ps_d  = ps_q;
    idx_d = idx_q;
    if (en) ps_d = tick ? '0 : ps_q + PW'(1);
    if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);
    fd_d  = wrap;

    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    if (en && !blank_cur) begin
      an_d  = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
      seg_d = nib_seg;
      dp_d  = nib_dp;
    end
  end

  // display only changes at a frame wrap, or at once while dark
  always_comb begin
    pend_d = pend_q;
    pdp_d  = pdp_q;
    pvld_d = pvld_q;
    disp_d = disp_q;
    ddp_d  = ddp_q;
    if (wrap) begin
      pvld_d = 1'b0;
      if (load) begin
        disp_d = din;
        ddp_d  = dp_in;
      end else if (pvld_q) begin
        disp_d = pend_q;
        ddp_d  = pdp_q;
      end
    end else begin
      if (!en && pvld_q) begin
        disp_d = pend_q;
        ddp_d  = pdp_q;
        pvld_d = 1'b0;
      end
      if (load) begin
        pend_d = din;
        pdp_d  = dp_in;
        pvld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q   <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      pdp_q  <= '0;
      pvld_q <= 1'b0;
      disp_q <= '0;
      ddp_q  <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      pdp_q  <= pdp_d;
      pvld_q <= pvld_d;
      disp_q <= disp_d;
      ddp_q  <= ddp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      fd_q   <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: expected outputs are queued
// with the cycle they must appear on; a monitor pops and compares.
module tb_seg7_scan_ctrl;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] SF = 7'b1110001;
  localparam logic [6:0] SB = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset, en, load, blank_lz;
  logic [15:0] din;
  logic [3:0]  dp_in, an;
  logic [6:0]  seg;
  logic        dp, frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS    (4),
    .CLK_DIV       (4),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .din        (din),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;
  int   b;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_run++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)",
                 e.nm, e.cyc, cyc);
      end else if (an !== e.an || seg !== e.seg ||
                   dp !== e.dp || frame_done !== e.fd) begin
        n_fail++;
        $display({"FAIL %s @%0d: got an=%b seg=%b dp=%b fd=%b,",
                  " want an=%b seg=%b dp=%b fd=%b"},
                 e.nm, cyc, an, seg, dp, frame_done,
                 e.an, e.seg, e.dp, e.fd);
      end
    end
  end

  task automatic push(input int c, input logic [3:0] a,
                      input logic [6:0] s, input logic d,
                      input logic f, input string nm);
    exp_t e;
    e.cyc = c;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    e.fd  = f;
    e.nm  = nm;
    sbq.push_back(e);
  endtask

  // segs = {d3,d2,d1,d0}; first and last cycle of each digit slot
  task automatic push_frame(input int fb, input logic [27:0] segs,
                            input logic [3:0] lit,
                            input logic [3:0] dps, input string nm);
    logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      a = lit[i] ? ~(4'b0001 << i) : 4'b1111;
      push(fb + 4*i, a, segs[7*i +: 7], dps[i], 1'b0, nm);
      push(fb + 4*i + 3, a, segs[7*i +: 7], dps[i], i == 3, nm);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    load     = 1'b1;
    din      = 16'h1234;
    dp_in    = 4'hF;
    blank_lz = 1'b0;
    push(2, 4'hF, SB, 1'b0, 1'b0, "reset_a");
    push(3, 4'hF, SB, 1'b0, 1'b0, "reset_b");
    @(negedge clk);
    goto(3);
    reset = 1'b0;
    din   = 16'h12AF;
    dp_in = 4'h0;
    b     = 4;
    push_frame(b, {S0, S0, S0, S0}, 4'hF, 4'h0, "rst_frame0");
    push_frame(b + 16, {S1, S2, SA, SF}, 4'hF, 4'h0, "12AF_f1");
    push_frame(b + 32, {S1, S2, SA, SF}, 4'hF, 4'h0, "12AF_f2");
    goto(4);
    load = 1'b0;

    goto(b + 40);
    din  = 16'h2222;
    load = 1'b1;
    push_frame(b + 48, {S2, S2, S2, S2}, 4'hF, 4'h0, "tear_2222");
    goto(b + 41);
    load = 1'b0;
    goto(b + 50);
    din  = 16'h7777;
    load = 1'b1;
    goto(b + 51);
    load = 1'b0;
    goto(b + 53);
    din  = 16'h1111;
    load = 1'b1;
    push_frame(b + 64, {S1, S1, S1, S1}, 4'hF, 4'h0, "tear_1111");
    goto(b + 54);
    load = 1'b0;

    goto(b + 78);
    din  = 16'h4321;
    load = 1'b1;
    push_frame(b + 80, {S4, S3, S2, S1}, 4'hF, 4'h0, "bnd_load");
    push_frame(b + 96, {S4, S3, S2, S1}, 4'hF, 4'h0, "bnd_hold");
    goto(b + 79);
    load = 1'b0;

    goto(b + 100);
    din  = 16'h0050;
    load = 1'b1;
    push_frame(b + 112, {SB, SB, S5, S0}, 4'b0011, 4'h0, "lz_0050");
    goto(b + 101);
    load = 1'b0;
    goto(b + 111);
    blank_lz = 1'b1;
    goto(b + 116);
    din  = 16'h0000;
    load = 1'b1;
    push_frame(b + 128, {SB, SB, SB, S0}, 4'b0001, 4'h0, "lz_zero");
    goto(b + 117);
    load = 1'b0;

    goto(b + 132);
    dp_in = 4'b0100;
    load  = 1'b1;
    push_frame(b + 144, {SB, SB, SB, S0}, 4'b0001, 4'h0, "dp_blank");
    goto(b + 133);
    load = 1'b0;
    goto(b + 159);
    blank_lz = 1'b0;
    push_frame(b + 160, {S0, S0, S0, S0}, 4'hF, 4'b0100, "dp_show");

    push(b + 176, 4'b1110, S0, 1'b0, 1'b0, "en_d0");
    push(b + 179, 4'b1110, S0, 1'b0, 1'b0, "en_d0");
    push(b + 180, 4'b1101, S0, 1'b0, 1'b0, "en_pre");
    push(b + 181, 4'b1101, S0, 1'b0, 1'b0, "en_pre");
    push(b + 182, 4'b1111, SB, 1'b0, 1'b0, "en_off");
    push(b + 186, 4'b1111, SB, 1'b0, 1'b0, "en_off");
    push(b + 191, 4'b1111, SB, 1'b0, 1'b0, "en_off");
    push(b + 192, 4'b1101, S5, 1'b0, 1'b0, "en_resume");
    push(b + 193, 4'b1101, S5, 1'b0, 1'b0, "en_resume");
    push(b + 194, 4'b1011, S5, 1'b0, 1'b0, "en_next");
    push(b + 200, 4'b0111, S5, 1'b0, 1'b0, "en_fd_pre");
    push(b + 201, 4'b0111, S5, 1'b0, 1'b1, "en_fd");
    push(b + 202, 4'b1110, S5, 1'b0, 1'b0, "en_fd_post");
    goto(b + 181);
    en = 1'b0;
    goto(b + 184);
    din   = 16'h5555;
    dp_in = 4'h0;
    load  = 1'b1;
    goto(b + 185);
    load = 1'b0;
    goto(b + 191);
    en = 1'b1;

    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d checks left, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. Holds a 16-bit hex value and steps through the digits at a fixed rate. For each digit it selects one nibble, decodes it with the existing hex-to-seven-segment decoder BCD7, and drives the matching anode. It sits between the CPU/debug register that supplies the value and the board display pins. New values are double-buffered and applied only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; nibble i of the value drives digit i.
CLK_DIV, 50000, clk cycles each digit is held; must be >= 2.
AN_ACTIVE_LOW, 1, 1 = anodes are driven 0 when on; 0 = driven 1 when on.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
en  in  1  scan enable; 0 = display dark and scan frozen.
load  in  1  single-cycle strobe; captures din and dp_in into the pending buffer.
din  in  4*NUM_DIGITS  hex value to show.
dp_in  in  NUM_DIGITS  decimal-point request per digit.
blank_lz  in  1  1 = suppress leading-zero digits.
an  out  NUM_DIGITS  anode select, registered; active level set by AN_ACTIVE_LOW.
seg  out  7  segment pattern {g..a}, active-high, registered.
dp  out  1  decimal point for the current digit, active-high, registered.
frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - pending and display registers = 0; pend_valid = 0.
  - prescaler = 0; digit index = 0.
  - an = all off (all 1s when AN_ACTIVE_LOW); seg = 0; dp = 0; frame_done = 0.
  - Reset has priority over every other input, including a load in the same cycle.
- Prescaler:
  - While en=1, counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and the digit index advances; the index wraps from NUM_DIGITS-1 to 0.
  - frame_done = 1 for exactly the cycle after the index wraps NUM_DIGITS-1 -> 0; 0 otherwise.
- Load and buffering:
  - load=1 writes din/dp_in into the pending register and sets pend_valid.
  - Repeated loads before a frame boundary: the last one wins.
  - Frame boundary = the cycle the index wraps to 0. At the boundary, if pend_valid, pending is copied to display and pend_valid clears.
  - load in the same cycle as the boundary: the new din goes straight to display and pend_valid stays 0.
  - While en=0, pending is copied to display on the next cycle; no frame boundary is needed.
- Output path:
  - The current index selects nibble display[4*idx +: 4], which feeds a combinational BCD7 instance.
  - an, seg and dp are registered from the index/display state, so they change exactly 1 cycle after the index changes.
  - Exactly one anode is on while enabled and the digit is not blanked.
- Leading-zero blanking:
  - With blank_lz=1, digit i (i>0) is blanked if nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A blanked digit: anode off, seg = 0, dp = 0. Its time slot is still consumed, so the refresh rate is constant.
  - A dp request on a blanked digit is suppressed.
- en=0:
  - Prescaler and index hold their values.
  - Next cycle: an = all off, seg = 0, dp = 0, frame_done = 0.
  - When en returns to 1, the scan resumes from the held index/prescaler with no restart.

Decomposition:
- Package seg7_pkg holds:
  - AN_OFF(n) helper or constant (all inactive, honouring AN_ACTIVE_LOW).
  - SEG_BLANK = 7'b0.
  - Digit index width = clog2(NUM_DIGITS), with a minimum of 1.
- One sub-module instance: BCD7 (existing decoder), used unchanged.
- Prescaler, index counter, buffering and blank logic stay in the top level; none is large enough to justify its own module.

Test Plan (CLK_DIV=4, NUM_DIGITS=4, AN_ACTIVE_LOW=1):
1. Reset with load=1, din=16'h1234 -> an=4'b1111, seg=0, dp=0, frame_done=0. The first frame after release shows 0 on every digit.
2. load din=16'h12AF, then run 2 frames -> second frame: an 1110/seg 1110001 (F), 1101/1110111 (A), 1011/1011011 (2), 0111/0000110 (1). Each digit is held 4 cycles; frame_done pulses once per 16 cycles.
3. Tear test: load 16'h1111 mid-frame while 16'h2222 is displayed -> remaining digits of that frame still show 2 (1011011); the next frame shows 1 (0000110) on all digits.
4. blank_lz=1, din=16'h0050 -> digits 3 and 2 have anode off and seg=0. Digit 1 shows 5 (1101101), digit 0 shows 0 (0111111). din=0 -> only digit 0 lit with 0111111.
5. en driven low for 10 cycles mid-digit -> an=1111 and seg=0 from the next cycle. On re-enable, the same digit resumes with the remaining prescaler count and frame_done timing is shifted by exactly 10 cycles.
6. dp_in=4'b0100, blank_lz=0, din=16'h0000 -> dp=1 only during digit 2's slot; with blank_lz=1 the dp is suppressed because digit 2 is blanked.
